// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one 16-bit approximate adder (7 approximate LSBs, 9 exact MSBs) over a 2-stage pipeline.
// Define APPROX_ERR_MON_EN to build the exact reference adder, |error| output and saturating error counter.
module approx_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDW-1:0]     res_id,
  output logic [16:0]        res_sum,
  output logic [16:0]        res_err,
  output logic [15:0]        err_cnt
);
  localparam int DATA_W = 16;
  localparam int APX_W  = 7;

  function automatic logic [DATA_W:0] approx_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    logic            c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < APX_W) begin
        s[i] = (~x[i] & (y[i] | c)) | (x[i] & y[i] & c);
        c    = x[i];
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
    end
    s[DATA_W] = c;
    return s;
  endfunction

  logic                vld_p1, vld_p2;
  logic                s2_take, s1_load, load_p2, any_req, accept;
  logic [IDW-1:0]      ptr, win, ptr_nxt;
  logic [DATA_W-1:0]   a_sel, b_sel, a_p1, b_p1;
  logic [IDW-1:0]      id_p1, id_p2;
  logic [DATA_W:0]     sum_p1, sum_p2;

  // S2 takes new data when empty or draining; S1 loads when empty or emptying into S2.
  assign s2_take = ~vld_p2 | res_ready;
  assign s1_load = ~vld_p1 | s2_take;
  assign load_p2 = s2_take & vld_p1;

  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        win     = IDW'(i);
      end
    end
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(ptr))) win = IDW'(i);
    end
  end

  assign accept  = any_req & s1_load & ~rst;
  assign ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (win == IDW'(i));
      if (win == IDW'(i)) begin
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ptr    <= '0;
    end else begin
      if (s1_load) vld_p1 <= accept;
      if (s2_take) vld_p2 <= vld_p1;
      if (accept)  ptr    <= ptr_nxt;
    end
  end

  // ---- stage p1: operand register ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= a_sel;
      b_p1  <= b_sel;
      id_p1 <= win;
    end
  end

  assign sum_p1 = approx_add(a_p1, b_p1);

  // ---- stage p2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p2 <= '0;
      id_p2  <= '0;
    end else if (load_p2) begin
      sum_p2 <= sum_p1;
      id_p2  <= id_p1;
    end
  end

  assign res_valid = vld_p2 & ~rst;
  assign res_sum   = sum_p2;
  assign res_id    = id_p2;

`ifdef APPROX_ERR_MON_EN
  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W:0] x,
                                               input logic [DATA_W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic [DATA_W:0] exact_p1, err_p1, err_p2;
  logic [15:0]     cnt_p2;

  assign exact_p1 = {1'b0, a_p1} + {1'b0, b_p1};
  assign err_p1   = abs_diff(exact_p1, sum_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_p2 <= '0;
      cnt_p2 <= '0;
    end else if (load_p2) begin
      err_p2 <= err_p1;
      if (err_p1 != '0) cnt_p2 <= sat_inc(cnt_p2);
    end
  end

  assign res_err = err_p2;
  assign err_cnt = cnt_p2;
`else
  assign res_err = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter: directed operand vectors with hand-computed sums,
// expectations queued at issue time and checked by an independent result monitor.
module tb_approx_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef APPROX_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid, res_ready;
  logic [IDW-1:0]     res_id;
  logic [16:0]        res_sum, res_err;
  logic [15:0]        err_cnt;
  logic [15:0]        a_arr [NREQ];
  logic [15:0]        b_arr [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = a_arr[i];
      req_b[i*16 +: 16] = b_arr[i];
    end
  end

  approx_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_sum(res_sum), .res_err(res_err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [16:0]    sum;
    logic [16:0]    err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  localparam logic [1:0]  D_ID [6] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3};
  localparam logic [15:0] D_A  [6] = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h007F, 16'h0055, 16'h0003};
  localparam logic [15:0] D_B  [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h002A, 16'h0003};
  localparam logic [16:0] D_S  [6] = '{17'h00002, 17'h00100, 17'h1FFFE, 17'h00080, 17'h000AA, 17'h00006};
  localparam logic [16:0] D_E  [6] = '{17'h1, 17'h0, 17'h0, 17'h1, 17'h2B, 17'h0};

  localparam logic [15:0] RR_A [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                                      16'h0500, 16'h0600, 16'h0700, 16'hFF80};
  localparam logic [15:0] RR_B [8] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                      16'h0005, 16'h0006, 16'h0007, 16'h0085};
  localparam logic [16:0] RR_S [8] = '{17'h00101, 17'h00202, 17'h00303, 17'h00404,
                                      17'h00505, 17'h00606, 17'h00707, 17'h10005};

  localparam logic [15:0] BP_A [4] = '{16'h1100, 16'h2200, 16'h3300, 16'h4400};
  localparam logic [15:0] BP_B [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  localparam logic [16:0] BP_S [4] = '{17'h01111, 17'h02222, 17'h03333, 17'h04444};
  localparam logic [3:0]  BP_RDY [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input logic [1:0] id, input logic [16:0] s, input logic [16:0] e);
    exp_t t;
    t.id  = IDW'(id);
    t.sum = s;
    t.err = MON ? e : 17'd0;
    exp_q.push_back(t);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                      input logic [16:0] s, input logic [16:0] e);
    logic ok;
    a_arr[id] = a;
    b_arr[id] = b;
    req_valid[id] = 1'b1;
    expect_res(id, s, e);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("send_accept", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 200);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Result monitor: pops one expectation per accepted result.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d sum=%h, expected no result", res_id, res_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_id",  32'(res_id),  32'(mon_e.id));
        chk("res_sum", 32'(res_sum), 32'(mon_e.sum));
        chk("res_err", 32'(res_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    logic       acc;
    logic [1:0] g;
    int         vi;
    int         nacc;

    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    // Reset with every requester asking
    rst = 1'b1;
    req_valid = 4'hF;
    a_arr[0] = 16'h0100;
    b_arr[0] = 16'h0001;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("rst_req_ready2", 32'(req_ready), 32'd0);
    chk("rst_res_valid2", 32'(res_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_res(2'd0, 17'h00101, 17'h0);
    @(negedge clk);
    chk("first_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Exact and inexact directed vectors
    for (int i = 0; i < 6; i++) send(D_ID[i], D_A[i], D_B[i], D_S[i], D_E[i]);
    drain();
    chk("err_cnt_directed", 32'(err_cnt), MON ? 32'd3 : 32'd0);

    // Round-robin with all requesters active
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = RR_A[i];
      b_arr[i] = RR_B[i];
    end
    for (int k = 0; k < 8; k++) expect_res(2'(k), RR_S[k], 17'h0);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) chk("rr_res_valid", 32'(res_valid), 32'd1);
      @(posedge clk);
      #1;
      g = 2'(k);
      if (k < 4) begin
        a_arr[g] = RR_A[k+4];
        b_arr[g] = RR_B[k+4];
      end else begin
        req_valid[g] = 1'b0;
      end
    end
    drain();

    // Backpressure on a single requester, then release
    a_arr[1] = BP_A[0];
    b_arr[1] = BP_B[0];
    expect_res(2'd1, BP_S[0], 17'h0);
    res_ready = 1'b0;
    req_valid = 4'b0010;
    vi = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) res_ready = 1'b1;
      @(negedge clk);
      acc = req_valid[1] & req_ready[1];
      if (c < 5) chk("bp_req_ready", 32'(req_ready), 32'(BP_RDY[c]));
      if (c >= 2 && c < 5) begin
        chk("bp_hold_valid", 32'(res_valid), 32'd1);
        chk("bp_hold_sum", 32'(res_sum), 32'h01111);
        chk("bp_hold_id", 32'(res_id), 32'd1);
      end
      if (c == 5 || c == 6) chk("single_req_accept", 32'(acc), 32'd1);
      @(posedge clk);
      #1;
      if (acc) begin
        vi++;
        if (vi < 4) begin
          a_arr[1] = BP_A[vi[1:0]];
          b_arr[1] = BP_B[vi[1:0]];
          expect_res(2'd1, BP_S[vi[1:0]], 17'h0);
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    drain();

    // Reset while both stages are full
    res_ready = 1'b0;
    a_arr[1] = 16'h1234;
    b_arr[1] = 16'h4321;
    req_valid = 4'b0010;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mf_full_valid", 32'(res_valid), 32'd1);
    chk("mf_stall_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("mf_rst_valid", 32'(res_valid), 32'd0);
    chk("mf_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mf_no_stale", 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef APPROX_ERR_MON_EN
    // Error counter saturation with a stream of inexact results
    do_reset(1);
    a_arr[0] = 16'h0001;
    b_arr[0] = 16'h0000;
    req_valid = 4'b0001;
    nacc = 0;
    for (int n = 0; n < 70000 && nacc < 32'h10005; n++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        nacc++;
        expect_res(2'd0, 17'h00002, 17'h1);
      end
      @(posedge clk);
      #1;
      if (nacc == 32'h10005) req_valid[0] = 1'b0;
    end
    drain();
    chk("sat_accepts", 32'(nacc), 32'h10005);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
`else
    nacc = 0;
    chk("err_cnt_off", 32'(err_cnt), 32'(nacc));
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
